// File: rtl/perf_timer_pkg.sv
// rtl/perf_timer_pkg.sv - shared offsets, CTRL bit indices and channel state type
//
// Purpose: definitions shared by the channel and the bus-facing top.
//   OFF_*   : word offsets inside a channel's 4-word register window
//   CTRL_*  : bit positions inside the CTRL register
//   ch_state_e : per-channel timer state
package perf_timer_pkg;

  localparam logic [1:0] OFF_LO   = 2'd0;
  localparam logic [1:0] OFF_HI   = 2'd1;
  localparam logic [1:0] OFF_CTRL = 2'd2;
  localparam logic [1:0] OFF_LAST = 2'd3;

  localparam int CTRL_RUNNING  = 0;
  localparam int CTRL_DONE     = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_OVF      = 3;
  localparam int CTRL_SW_START = 4;
  localparam int CTRL_SW_CLEAR = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ch_state_e;

endpackage

// File: rtl/perf_timer_channel.sv
// rtl/perf_timer_channel.sv - one cycle-timer channel: FSM, counter, LAST, shadow, flags
//
// Purpose: counts clk cycles between a start and a stop event and keeps the result.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   hw_start, hw_stop     one-cycle hardware start / stop pulses
//   ctrl_wr               CTRL register write strobe for this channel
//   wr_done, wr_irq_en,
//   wr_ovf, wr_sw_start,
//   wr_sw_clear           CTRL write data bits
//   lo_rd                 COUNT_LO read strobe; latches the counter's upper bits
//   count_lo              counter[31:0]
//   shadow                counter upper bits captured at the last COUNT_LO read
//   last                  last completed duration[31:0]
//   ctrl_bits             {ovf, irq_en, done, running}
//   irq_term              registered done & irq_en
module perf_timer_channel
  import perf_timer_pkg::*;
#(
  parameter int CNT_W = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hw_start,
  input  logic             hw_stop,
  input  logic             ctrl_wr,
  input  logic             wr_done,
  input  logic             wr_irq_en,
  input  logic             wr_ovf,
  input  logic             wr_sw_start,
  input  logic             wr_sw_clear,
  input  logic             lo_rd,
  output logic [31:0]      count_lo,
  output logic [CNT_W-33:0] shadow,
  output logic [31:0]      last,
  output logic [3:0]       ctrl_bits,
  output logic             irq_term
);

  ch_state_e            state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-33:0]    shadow_q, shadow_d;
  logic [31:0]          last_q, last_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic                 irq_en_q, irq_en_d;
  logic                 irq_q, irq_d;

  logic                 start;
  logic                 sw_clear;
  logic                 cnt_max;
  logic [CNT_W-1:0]     cnt_inc;

  always_comb begin
    start    = hw_start | (ctrl_wr & wr_sw_start);
    sw_clear = ctrl_wr & wr_sw_clear;
    cnt_max  = (count_q == {CNT_W{1'b1}});
    // Saturating increment; also the source of the stop-time duration.
    cnt_inc  = cnt_max ? count_q : count_q + CNT_W'(1);

    state_d  = state_q;
    count_d  = count_q;
    last_d   = last_q;
    shadow_d = shadow_q;
    done_d   = done_q & ~(ctrl_wr & wr_done);
    ovf_d    = ovf_q  & ~(ctrl_wr & wr_ovf);
    irq_en_d = ctrl_wr ? wr_irq_en : irq_en_q;
    irq_d    = done_q & irq_en_q;

    // Snapshot the high half together with the low-half read so software
    // sees a coherent value even if the low half rolls over in between.
    if (lo_rd) shadow_d = count_q[CNT_W-1:32];

    if (sw_clear) begin
      state_d = IDLE;
      count_d = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (state_q == RUN) begin
      // A stop in RUN takes priority over a coincident start.
      if (cnt_max) ovf_d = 1'b1;
      if (hw_stop) begin
        state_d = DONE;
        done_d  = 1'b1;
        last_d  = cnt_inc[31:0];
      end else begin
        count_d = cnt_inc;
      end
    end else if (start) begin
      state_d = RUN;
      count_d = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      shadow_q <= '0;
      last_q   <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      last_q   <= last_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign count_lo  = count_q[31:0];
  assign shadow    = shadow_q;
  assign last      = last_q;
  assign ctrl_bits = {ovf_q, irq_en_q, done_q, (state_q == RUN)};
  assign irq_term  = irq_q;

endmodule

// File: rtl/avalon_perf_timer.sv
// rtl/avalon_perf_timer.sv - multi-channel Avalon-MM cycle timer
//
// Purpose: NUM_CH cycle timers behind a word-addressed Avalon-MM slave.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   address, read, write,
//   writedata              Avalon-MM slave request
//   readdata               registered read data, valid the cycle after read
//   hw_start, hw_stop      per-channel start / stop pulses
//   irq                    OR over channels of registered done & irq_en
module avalon_perf_timer
  import perf_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 48,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [NUM_CH-1:0] hw_start,
  input  logic [NUM_CH-1:0] hw_stop,
  output logic              irq
);

  logic [ADDR_W-1:0] ch_sel;
  logic [1:0]        off;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] ch_irq;

  logic [31:0]       ch_lo     [NUM_CH];
  logic [CNT_W-33:0] ch_shadow [NUM_CH];
  logic [31:0]       ch_last   [NUM_CH];
  logic [3:0]        ch_ctrl   [NUM_CH];

  logic [31:0]       rd_word;
  logic [31:0]       readdata_q, readdata_d;

  // Bits of writedata that no register field uses.
  logic              unused_wdata;
  assign unused_wdata = ^{writedata[31:6], writedata[0]};

  assign ch_sel = address >> 2;
  assign off    = address[1:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign hit[c] = (ch_sel == ADDR_W'(c));

    perf_timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .hw_start    (hw_start[c]),
      .hw_stop     (hw_stop[c]),
      .ctrl_wr     (write & hit[c] & (off == OFF_CTRL)),
      .wr_done     (writedata[CTRL_DONE]),
      .wr_irq_en   (writedata[CTRL_IRQ_EN]),
      .wr_ovf      (writedata[CTRL_OVF]),
      .wr_sw_start (writedata[CTRL_SW_START]),
      .wr_sw_clear (writedata[CTRL_SW_CLEAR]),
      .lo_rd       (read & hit[c] & (off == OFF_LO)),
      .count_lo    (ch_lo[c]),
      .shadow      (ch_shadow[c]),
      .last        (ch_last[c]),
      .ctrl_bits   (ch_ctrl[c]),
      .irq_term    (ch_irq[c])
    );
  end

  // Addresses beyond the last channel match no hit bit and read as zero.
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hit[c]) begin
        case (off)
          OFF_LO:   rd_word = ch_lo[c];
          OFF_HI:   rd_word = 32'(ch_shadow[c]);
          OFF_CTRL: rd_word = {28'd0, ch_ctrl[c]};
          default:  rd_word = ch_last[c];
        endcase
      end
    end
    readdata_d = read ? rd_word : readdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |ch_irq;

endmodule

// File: tb/tb_avalon_perf_timer.sv
// tb/tb_avalon_perf_timer.sv - scoreboard bench with timestamp-based reference model
module tb_avalon_perf_timer;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 48;
  localparam int ADDR_W = 5;
  localparam int NW     = 4 * NUM_CH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic [ADDR_W-1:0] address = '0;
  logic              read = 1'b0, write = 1'b0;
  logic [31:0]       writedata = '0, readdata;
  logic [NUM_CH-1:0] hw_start = '0, hw_stop = '0;
  logic              irq;

  logic              reset33 = 1'b1;
  logic [1:0]        address33 = '0;
  logic              read33 = 1'b0, write33 = 1'b0;
  logic [31:0]       writedata33 = '0, readdata33;
  logic [0:0]        hw_start33 = '0, hw_stop33 = '0;
  logic              irq33;

  avalon_perf_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .hw_start(hw_start),
    .hw_stop(hw_stop), .irq(irq)
  );

  avalon_perf_timer #(.NUM_CH(1), .CNT_W(33), .ADDR_W(2)) dut33 (
    .clk(clk), .reset(reset33), .address(address33), .read(read33), .write(write33),
    .writedata(writedata33), .readdata(readdata33), .hw_start(hw_start33),
    .hw_stop(hw_stop33), .irq(irq33)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard queues: expected read data pushed at issue, popped by the monitor.
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] exp33_q[$];
  string       name33_q[$];

  logic rd_pend = 1'b0, rd_pend33 = 1'b0;
  always @(posedge clk) begin
    rd_pend   <= read;
    rd_pend33 <= read33;
  end

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected: got 0x%0h expected none", readdata);
      end else begin
        chk(name_q.pop_front(), {32'd0, readdata}, {32'd0, exp_q.pop_front()});
      end
    end
    if (rd_pend33) begin
      if (exp33_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd33_unexpected: got 0x%0h expected none", readdata33);
      end else begin
        chk(name33_q.pop_front(), {32'd0, readdata33}, {32'd0, exp33_q.pop_front()});
      end
    end
  end

  // Reference model: each channel is described by its start/stop timestamps.
  // st: 0 idle, 1 running, 2 done. Count in cycle n while running = n - start - 1.
  int     st     [NUM_CH];
  longint s_t    [NUM_CH];
  longint p_t    [NUM_CH];
  bit     dn     [NUM_CH];
  bit     en     [NUM_CH];
  longint last_m [NUM_CH];
  longint shad   [NUM_CH];
  longint now = 0;
  bit     irq_pend = 1'b0;

  function automatic longint cnt_of(input int c);
    if (st[c] == 1) return now - s_t[c] - 1;
    if (st[c] == 2) return p_t[c] - s_t[c] - 1;
    return 0;
  endfunction

  function automatic logic [31:0] exp_read(input int a);
    int c = a / 4;
    int o = a % 4;
    if (c >= NUM_CH) return 32'd0;
    case (o)
      0:       return 32'(cnt_of(c));
      1:       return 32'(shad[c]);
      2:       return {28'd0, 1'b0, en[c], dn[c], (st[c] == 1)};
      default: return 32'(last_m[c]);
    endcase
  endfunction

  task automatic model_apply(input logic [NUM_CH-1:0] hs, input logic [NUM_CH-1:0] hp,
                             input bit wr, input int a, input logic [31:0] wd);
    for (int c = 0; c < NUM_CH; c++) begin
      bit w = wr && (a / 4 == c) && (a % 4 == 2);
      if (w) en[c] = wd[2];
      if (w && wd[1]) dn[c] = 1'b0;
      if (w && wd[5]) begin
        st[c] = 0; dn[c] = 1'b0;
      end else if (st[c] == 1) begin
        if (hp[c]) begin
          st[c] = 2; p_t[c] = now; last_m[c] = now - s_t[c]; dn[c] = 1'b1;
        end
      end else if (hs[c] || (w && wd[4])) begin
        st[c] = 1; s_t[c] = now; dn[c] = 1'b0;
      end
    end
  endtask

  // One bus/pulse cycle on the main instance; also checks irq every cycle.
  task automatic cyc(input logic [NUM_CH-1:0] hs, input logic [NUM_CH-1:0] hp,
                     input bit rd, input bit wr, input int a, input logic [31:0] wd,
                     input bit frc);
    @(negedge clk);
    chk("irq", {63'd0, irq}, {63'd0, irq_pend});
    if (frc) begin
      force dut.g_ch[1].u_ch.count_q = 48'h0000_FFFF_FFFF;
      s_t[1] = now - 64'h0000_0000_FFFF_FFFF - 1;
      #1;
      release dut.g_ch[1].u_ch.count_q;
    end
    hw_start = hs; hw_stop = hp; read = rd; write = wr;
    address = a[ADDR_W-1:0]; writedata = wd;
    if (rd) begin
      exp_q.push_back(exp_read(a));
      name_q.push_back($sformatf("rd_a%0d_t%0d", a, now));
      if (a < NW && a % 4 == 0) shad[a / 4] = cnt_of(a / 4) >>> 32;
    end
    irq_pend = 1'b0;
    for (int c = 0; c < NUM_CH; c++) if (dn[c] && en[c]) irq_pend = 1'b1;
    model_apply(hs, hp, wr, a, wd);
    now++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0, 1'b0, 1'b0, 0, 32'd0, 1'b0);
  endtask

  task automatic rd(input int a);
    cyc('0, '0, 1'b1, 1'b0, a, 32'd0, 1'b0);
  endtask

  // Directed cycle on the CNT_W=33 instance; expected value supplied directly.
  task automatic c33(input bit rst, input bit hs, input bit r, input int a,
                     input logic [31:0] e, input bit frc);
    @(negedge clk);
    if (frc) begin
      force dut33.g_ch[0].u_ch.count_q = 33'h1_FFFF_FFFD;
      #1;
      release dut33.g_ch[0].u_ch.count_q;
    end
    reset33 = rst; hw_start33 = hs; read33 = r; address33 = a[1:0];
    if (r) begin
      exp33_q.push_back(e);
      name33_q.push_back($sformatf("rd33_a%0d", a));
    end
  endtask

  initial begin
    logic [NUM_CH-1:0] hs;
    logic [31:0] wd;
    int op, a;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_readdata", {32'd0, readdata}, 64'd0);
    chk("rst_irq", {63'd0, irq}, 64'd0);

    // Reset state: every word, mapped or not, reads zero.
    for (int i = 0; i < 32; i++) rd(i);

    // Channel 0: start at t, stop at t+100.
    cyc(4'b0001, '0, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    idle(99);
    cyc('0, 4'b0001, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    rd(3); rd(2); rd(6); rd(7);

    // Channel 1: coherent high-half snapshot across a low-half rollover.
    cyc(4'b0010, '0, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    idle(3);
    cyc('0, '0, 1'b1, 1'b0, 4, 32'd0, 1'b1);
    idle(3);
    rd(5);
    rd(4);
    rd(5);
    cyc('0, 4'b0010, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    rd(7);

    // Channel 2: irq rise after done, fall after W1C.
    cyc('0, '0, 1'b0, 1'b1, 10, 32'h4, 1'b0);
    cyc(4'b0100, '0, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    idle(10);
    cyc('0, 4'b0100, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    idle(4);
    rd(10);
    cyc('0, '0, 1'b0, 1'b1, 10, 32'h2, 1'b0);
    idle(3);
    rd(10);

    // Channel 3: simultaneous-event priorities.
    cyc(4'b1000, 4'b1000, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    rd(14);
    idle(5);
    cyc(4'b1000, 4'b1000, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    rd(14); rd(15);
    cyc(4'b1000, '0, 1'b0, 1'b1, 14, 32'h20, 1'b0);
    rd(12); rd(14); rd(15);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++) hs[c] = ($urandom_range(15) == 0);
      op = $urandom_range(9);
      a  = $urandom_range(31);
      wd = $urandom;
      if ($urandom_range(3) != 0) wd[5] = 1'b0;
      if (op <= 5)
        cyc(hs, 4'($urandom_range(15)) & {4{($urandom_range(3) == 0)}}, 1'b1, 1'b0, a, 32'd0, 1'b0);
      else if (op <= 7)
        cyc(hs, '0, 1'b0, 1'b1, 4 * $urandom_range(NUM_CH - 1) + 2, wd, 1'b0);
      else if (op == 8)
        cyc(hs, '0, 1'b0, 1'b1, a, wd, 1'b0);
      else
        cyc(hs, 4'($urandom_range(15)), 1'b0, 1'b0, 0, 32'd0, 1'b0);
    end
    idle(3);

    // CNT_W=33 instance: saturation, then reset in the middle of a run.
    c33(1'b0, 1'b1, 1'b0, 0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) c33(1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    c33(1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) c33(1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    c33(1'b0, 1'b0, 1'b1, 0, 32'hFFFF_FFFF, 1'b0);
    c33(1'b0, 1'b0, 1'b1, 1, 32'h1, 1'b0);
    c33(1'b0, 1'b0, 1'b1, 2, 32'h9, 1'b0);
    c33(1'b0, 1'b0, 1'b1, 3, 32'h0, 1'b0);
    chk("irq33_no_en", {63'd0, irq33}, 64'd0);
    c33(1'b1, 1'b0, 1'b1, 0, 32'h0, 1'b0);
    c33(1'b0, 1'b0, 1'b1, 2, 32'h0, 1'b0);
    c33(1'b0, 1'b0, 1'b1, 0, 32'h0, 1'b0);
    c33(1'b0, 1'b0, 1'b1, 1, 32'h0, 1'b0);
    c33(1'b0, 1'b0, 1'b1, 3, 32'h0, 1'b0);
    c33(1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("sb33_drained", 64'(exp33_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
